matrix_result_serializer: RTL and testbench



---
 rtl/matrix_result_serializer.sv | 237 +++++++++++++++++++++++
 tb/tb_matrix_result_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer
//
// Reads a DIM x DIM signed result matrix from the multiplier's flattened
// result bus and streams the active N x N corner of it to the host-side
// output path, one element per valid/ready transfer.
//
// When start is seen in IDLE with a legal size, matrix_in and size are
// snapshotted into shadow registers. The stream is then produced only from
// that snapshot, so later activity on matrix_in or size does not affect it.
// A start with an illegal size raises a single-cycle err_size pulse and
// leaves the snapshot untouched.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      capture request; honoured only in IDLE
//   matrix_in  flattened matrix; element (r,c) at bit ELEM_W*(c + DIM*r)
//   size       active dimension N; legal range 1..DIM
//   busy       high while in STREAM
//   out_valid  out_data/out_row/out_col/out_last hold a valid element
//   out_ready  downstream accepts the element when high with out_valid
//   out_data   signed element value
//   out_row    source row of the presented element
//   out_col    source column of the presented element
//   out_last   presented element is (N-1,N-1)
//   done       one-cycle pulse after the final element is accepted
//   err_size   one-cycle pulse on start with an illegal size
//
// Build option
//   SERIALIZER_TRANSPOSE_EN  when defined, elements are emitted column-major
//                            (row index advances fastest). out_row/out_col
//                            still report the true source position and
//                            out_last is still raised at (N-1,N-1). The port
//                            list is the same in both builds.

module matrix_result_serializer #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ELEM_W*DIM*DIM-1:0] matrix_in,
  input  logic [7:0]                size,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ELEM_W-1:0]  out_data,
  output logic [2:0]                out_row,
  output logic [2:0]                out_col,
  output logic                      out_last,
  output logic                      done,
  output logic                      err_size
);

  localparam int NUM_ELEM = DIM * DIM;
  localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  // Snapshot of the matrix and the active dimension
  logic [ELEM_W-1:0] shadow [NUM_ELEM];
  logic [7:0]        size_reg;
  logic              capture;

  // Next-state values for the registered outputs
  logic              busy_next;
  logic              valid_next;
  logic [ELEM_W-1:0] data_next;
  logic [2:0]        row_next;
  logic [2:0]        col_next;
  logic              last_next;
  logic              done_next;
  logic              err_next;

  // Traversal helpers
  logic              size_legal;
  logic [2:0]        last_idx;
  logic [2:0]        adv_row;
  logic [2:0]        adv_col;
  logic [2:0]        pres_row;
  logic [2:0]        pres_col;

  // Linear position of element (r,c) inside the flattened layout
  function automatic logic [IDX_W-1:0] elem_idx(input logic [2:0] r,
                                                input logic [2:0] c);
    logic [15:0] lin;
    lin = 16'(r) * 16'(DIM) + 16'(c);
    return lin[IDX_W-1:0];
  endfunction

  assign size_legal = (size != 8'd0) && (size <= 8'(DIM));
  assign last_idx   = size_reg[2:0] - 3'd1;

  // Position that follows the currently presented element
  always_comb begin
    adv_row = out_row;
    adv_col = out_col;
`ifdef SERIALIZER_TRANSPOSE_EN
    if (out_row == last_idx) begin
      adv_row = 3'd0;
      adv_col = out_col + 3'd1;
    end else begin
      adv_row = out_row + 3'd1;
    end
`else
    if (out_col == last_idx) begin
      adv_col = 3'd0;
      adv_row = out_row + 3'd1;
    end else begin
      adv_col = out_col + 3'd1;
    end
`endif
  end

  // Snapshot storage; each element is only written on an accepted start
  generate
    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow[gi] <= '0;
        end else if (capture) begin
          shadow[gi] <= matrix_in[ELEM_W*gi +: ELEM_W];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_reg <= 8'd0;
    end else if (capture) begin
      size_reg <= size;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    valid_next = out_valid;
    data_next  = out_data;
    row_next   = out_row;
    col_next   = out_col;
    last_next  = out_last;
    done_next  = 1'b0;
    err_next   = 1'b0;
    pres_row   = 3'd0;
    pres_col   = 3'd0;

    case (state)
      IDLE: begin
        if (start) begin
          if (size_legal) begin
            capture    = 1'b1;
            state_next = STREAM;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      STREAM: begin
        // The first STREAM cycle has nothing presented yet: load (0,0)
        // from the snapshot, which was written on the previous edge.
        // Afterwards out_valid stays high until the final transfer.
        if (!out_valid) begin
          pres_row   = 3'd0;
          pres_col   = 3'd0;
          valid_next = 1'b1;
          row_next   = pres_row;
          col_next   = pres_col;
          data_next  = shadow[elem_idx(pres_row, pres_col)];
          last_next  = (pres_row == last_idx) && (pres_col == last_idx);
        end else if (out_ready) begin
          if (out_last) begin
            state_next = DONE;
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            pres_row  = adv_row;
            pres_col  = adv_col;
            row_next  = pres_row;
            col_next  = pres_col;
            data_next = shadow[elem_idx(pres_row, pres_col)];
            last_next = (pres_row == last_idx) && (pres_col == last_idx);
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
      end
    endcase

    busy_next = (state_next == STREAM);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= 3'd0;
      out_col   <= 3'd0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err_size  <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= busy_next;
      out_valid <= valid_next;
      out_data  <= data_next;
      out_row   <= row_next;
      out_col   <= col_next;
      out_last  <= last_next;
      done      <= done_next;
      err_size  <= err_next;
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Self-checking bench for matrix_result_serializer.
// Expected elements are pushed to a scoreboard queue when a stream is
// started and popped as the DUT transfers them.

module tb_matrix_result_serializer;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;

  logic                      clk;
  logic                      rst_n;
  logic                      start;
  logic [ELEM_W*DIM*DIM-1:0] matrix_in;
  logic [7:0]                size;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [ELEM_W-1:0]  out_data;
  logic [2:0]                out_row;
  logic [2:0]                out_col;
  logic                      out_last;
  logic                      done;
  logic                      err_size;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] r;
    logic [2:0] c;
    logic       l;
  } exp_t;

  exp_t q[$];
  logic signed [7:0] m [DIM][DIM];
  int tests_run = 0;
  int fails     = 0;

  matrix_result_serializer #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .matrix_in(matrix_in),
    .size     (size),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_last (out_last),
    .done     (done),
    .err_size (err_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the bench matrix onto the flattened bus
  task automatic load_matrix();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        matrix_in[8*(c + DIM*r) +: 8] = m[r][c];
  endtask

  // Expected emission order for an n x n stream
  task automatic push_expected(input int n);
    exp_t e;
    q.delete();
`ifdef SERIALIZER_TRANSPOSE_EN
    for (int c = 0; c < n; c++)
      for (int r = 0; r < n; r++) begin
`else
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
`endif
        e.d = m[r][c];
        e.r = 3'(r);
        e.c = 3'(c);
        e.l = (r == n-1) && (c == n-1);
        q.push_back(e);
      end
  endtask

  // Issue a start from a negedge; checks the one-cycle gap before out_valid
  task automatic do_start(input int n);
    start = 1'b1;
    size  = 8'(n);
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_latency: busy=%b out_valid=%b required busy=1 out_valid=0", busy, out_valid);
    end
  endtask

  // Drive out_ready and consume transfers against the scoreboard.
  // mode 0: ready always high; mode 1: ready toggles 1,0,1,0...
  // stop_after > 0 leaves the task after that many transfers are decided.
  task automatic run_stream(input string name, input int mode, input int stop_after,
                            input bit inject, output int nxfers);
    exp_t e;
    bit   prev_stall = 1'b0;
    bit   fin = 1'b0;
    logic [7:0] pd;
    logic [2:0] pr, pc;
    logic pl;
    int   cyc = 0;
    nxfers = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (inject && cyc == 5) begin
        start = 1'b1;
        size  = 8'd2;
        matrix_in = {(DIM*DIM){8'h7F}};
      end else if (inject && cyc == 6) begin
        start = 1'b0;
      end
      if (err_size !== 1'b0) begin
        tests_run++; fails++;
        $display("[TB] FAIL %s_err_size: err_size=%b required 0", name, err_size);
      end
      if (prev_stall) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== pd || out_row !== pr ||
            out_col !== pc || out_last !== pl) begin
          fails++;
          $display("[TB] FAIL %s_hold: v=%b d=%0d r=%0d c=%0d l=%b required v=1 d=%0d r=%0d c=%0d l=%b",
                   name, out_valid, out_data, out_row, out_col, out_last, $signed(pd), pr, pc, pl);
        end
      end
      out_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
      if (out_valid && out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          fails++;
          $display("[TB] FAIL %s_extra: element d=%0d r=%0d c=%0d beyond expected count",
                   name, out_data, out_row, out_col);
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || out_row !== e.r || out_col !== e.c || out_last !== e.l) begin
            fails++;
            $display("[TB] FAIL %s_elem%0d: d=%0d r=%0d c=%0d l=%b required d=%0d r=%0d c=%0d l=%b",
                     name, nxfers, out_data, out_row, out_col, out_last,
                     $signed(e.d), e.r, e.c, e.l);
          end
        end
        $display("[TB] %s xfer %0d: d=%0d r=%0d c=%0d l=%b", name, nxfers,
                 out_data, out_row, out_col, out_last);
        nxfers++;
        if (out_last === 1'b1) fin = 1'b1;
        if (stop_after > 0 && nxfers == stop_after) return;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pr = out_row; pc = out_col; pl = out_last;
    end
    if (!fin) begin
      tests_run++; fails++;
      $display("[TB] FAIL %s_timeout: no last transfer after %0d cycles", name, cyc);
      return;
    end
    // done cycle: pulse high, busy and out_valid low
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_done: done=%b busy=%b out_valid=%b required 1 0 0", name, done, busy, out_valid);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s_done_width: done=%b required 0", name, done);
    end
    tests_run++;
    if (q.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_missing: %0d elements never emitted, required 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; size = 8'd0; out_ready = 1'b0; matrix_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, out_valid, out_data, out_row, out_col, out_last, done, err_size} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state: busy=%b v=%b d=%0d r=%0d c=%0d l=%b done=%b err=%b required all 0",
               busy, out_valid, out_data, out_row, out_col, out_last, done, err_size);
    end
    $display("[TB] reset released");
  endtask

  task automatic test_full_row_major();
    int n;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[r][c] = 8'(5*r + c - 12);
    load_matrix();
    push_expected(5);
    do_start(5);
    run_stream("full5", 0, 0, 1'b0, n);
    tests_run++;
    if (n != 25) begin
      fails++;
      $display("[TB] FAIL full5_count: %0d transfers required 25", n);
    end
  endtask

  task automatic test_backpressure();
    int n;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[r][c] = 8'(10*r + c + 1);
    load_matrix();
    push_expected(3);
    do_start(3);
    run_stream("bp3", 1, 0, 1'b0, n);
    tests_run++;
    if (n != 9) begin
      fails++;
      $display("[TB] FAIL bp3_count: %0d transfers required 9", n);
    end
  endtask

  task automatic test_illegal_size();
    int bad [2] = '{0, 6};
    foreach (bad[i]) begin
      start = 1'b1;
      size  = 8'(bad[i]);
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if (err_size !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL illegal%0d_pulse: err=%b v=%b busy=%b required 1 0 0",
                 bad[i], err_size, out_valid, busy);
      end
      @(negedge clk);
      tests_run++;
      if (err_size !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL illegal%0d_after: err=%b v=%b busy=%b required 0 0 0",
                 bad[i], err_size, out_valid, busy);
      end
      $display("[TB] illegal size %0d checked", bad[i]);
    end
  endtask

  task automatic test_capture_isolation();
    int n;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[r][c] = 8'($urandom_range(0, 255));
    m[0][0] = 8'h80;
    load_matrix();
    push_expected(5);
    do_start(5);
    run_stream("iso5", 0, 0, 1'b1, n);
    tests_run++;
    if (n != 25) begin
      fails++;
      $display("[TB] FAIL iso5_count: %0d transfers required 25", n);
    end
  endtask

  task automatic test_async_reset();
    int n;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m[r][c] = 8'(r - c + 3);
    load_matrix();
    push_expected(5);
    do_start(5);
    run_stream("abort", 0, 7, 1'b0, n);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, out_valid, out_data, out_row, out_col, out_last, done, err_size} !== '0) begin
      fails++;
      $display("[TB] FAIL async_reset_outputs: busy=%b v=%b d=%0d r=%0d c=%0d l=%b done=%b required all 0",
               busy, out_valid, out_data, out_row, out_col, out_last, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL abort_no_done: done=%b v=%b required 0 0", done, out_valid);
      end
    end
    m[0][0] = 8'sh80;
    load_matrix();
    push_expected(1);
    do_start(1);
    run_stream("one", 0, 0, 1'b0, n);
    tests_run++;
    if (n != 1) begin
      fails++;
      $display("[TB] FAIL one_count: %0d transfers required 1", n);
    end
  endtask

  task automatic test_two_by_two();
    int n;
    m[0][0] = 8'd1; m[0][1] = 8'd2;
    m[1][0] = 8'd3; m[1][1] = 8'd4;
    load_matrix();
    push_expected(2);
    do_start(2);
    run_stream("two", 0, 0, 1'b0, n);
    tests_run++;
    if (n != 4) begin
      fails++;
      $display("[TB] FAIL two_count: %0d transfers required 4", n);
    end
  endtask

  initial begin
    test_reset();
    test_full_row_major();
    test_backpressure();
    test_illegal_size();
    test_capture_isolation();
    test_async_reset();
    test_two_by_two();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
